// File: rtl/nr_boot_sequencer.sv
// nr_boot_sequencer
//   Loads a program image into the nanoRisk core from a byte stream, then
//   releases the core from reset and counts its run cycles until it halts.
//   Stream format: ni, nd, ni instruction bytes, nd data bytes.
// Ports:
//   clk, reset        rising-edge clock, async active-low reset
//   start             one-cycle pulse, begins a load from IDLE or HALTED
//   in_data/in_valid  stream byte and its valid flag
//   in_ready          sequencer accepts a byte this cycle
//   im_wr_*           instruction memory write port (registered strobe)
//   dm_wr_*           data memory write port (registered strobe)
//   cpu_reset         active-high reset to the core
//   cpu_halted        core has executed halt (level)
//   busy, done        status: busy outside IDLE/HALTED, done in HALTED
//   run_cycles        saturating count of cycles spent in RUN
module nr_boot_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_wr_en,
  output logic [ADDR_W-1:0] im_wr_addr,
  output logic [DATA_W-1:0] im_wr_data,
  output logic              dm_wr_en,
  output logic [ADDR_W-1:0] dm_wr_addr,
  output logic [DATA_W-1:0] dm_wr_data,
  output logic              cpu_reset,
  input  logic              cpu_halted,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  run_cycles
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_I   = 3'd1,
    ST_HDR_D   = 3'd2,
    ST_LOAD_I  = 3'd3,
    ST_LOAD_D  = 3'd4,
    ST_RELEASE = 3'd5,
    ST_RUN     = 3'd6,
    ST_HALTED  = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ni_q, ni_d;
  logic [ADDR_W-1:0]   nd_q, nd_d;
  logic                im_wr_en_q, im_wr_en_d;
  logic [ADDR_W-1:0]   im_wr_addr_q, im_wr_addr_d;
  logic [DATA_W-1:0]   im_wr_data_q, im_wr_data_d;
  logic                dm_wr_en_q, dm_wr_en_d;
  logic [ADDR_W-1:0]   dm_wr_addr_q, dm_wr_addr_d;
  logic [DATA_W-1:0]   dm_wr_data_q, dm_wr_data_d;
  logic [CNT_W-1:0]    run_cycles_q, run_cycles_d;
  logic                accept_s;

  // Status decodes come straight from the state register, so they are glitch-free.
  assign in_ready  = (state_q == ST_HDR_I) || (state_q == ST_HDR_D) ||
                     (state_q == ST_LOAD_I) || (state_q == ST_LOAD_D);
  assign cpu_reset = (state_q != ST_RUN);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign done      = (state_q == ST_HALTED);
  assign accept_s  = in_valid && in_ready;

  assign im_wr_en   = im_wr_en_q;
  assign im_wr_addr = im_wr_addr_q;
  assign im_wr_data = im_wr_data_q;
  assign dm_wr_en   = dm_wr_en_q;
  assign dm_wr_addr = dm_wr_addr_q;
  assign dm_wr_data = dm_wr_data_q;
  assign run_cycles = run_cycles_q;

  // Next-state, byte counter, write-port and run-counter logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ni_d         = ni_q;
    nd_d         = nd_q;
    im_wr_en_d   = 1'b0;
    im_wr_addr_d = im_wr_addr_q;
    im_wr_data_d = im_wr_data_q;
    dm_wr_en_d   = 1'b0;
    dm_wr_addr_d = dm_wr_addr_q;
    dm_wr_data_d = dm_wr_data_q;
    run_cycles_d = run_cycles_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d      = ST_HDR_I;
          cnt_d        = {ADDR_W{1'b0}};
          run_cycles_d = {CNT_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_HDR_I: begin
        if (accept_s) begin
          ni_d    = ADDR_W'(in_data);
          state_d = ST_HDR_D;
        end else begin
          state_d = state_q;
        end
      end
      ST_HDR_D: begin
        if (accept_s) begin
          nd_d = ADDR_W'(in_data);
          if (ni_q != {ADDR_W{1'b0}}) begin
            state_d = ST_LOAD_I;
          end else if (in_data != {DATA_W{1'b0}}) begin
            state_d = ST_LOAD_D;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD_I: begin
        if (accept_s) begin
          im_wr_en_d   = 1'b1;
          im_wr_addr_d = cnt_q;
          im_wr_data_d = in_data;
          // Last instruction byte: the counter restarts for the data section.
          if (cnt_q == (ni_q - ADDR_W'(1))) begin
            cnt_d   = {ADDR_W{1'b0}};
            state_d = (nd_q != {ADDR_W{1'b0}}) ? ST_LOAD_D : ST_RELEASE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD_D: begin
        if (accept_s) begin
          dm_wr_en_d   = 1'b1;
          dm_wr_addr_d = cnt_q;
          dm_wr_data_d = in_data;
          if (cnt_q == (nd_q - ADDR_W'(1))) begin
            cnt_d   = {ADDR_W{1'b0}};
            state_d = ST_RELEASE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RELEASE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // The halting edge itself is not counted.
        if (cpu_halted) begin
          state_d = ST_HALTED;
        end else if (run_cycles_q != {CNT_W{1'b1}}) begin
          run_cycles_d = run_cycles_q + CNT_W'(1);
        end else begin
          run_cycles_d = run_cycles_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {ADDR_W{1'b0}};
      ni_q         <= {ADDR_W{1'b0}};
      nd_q         <= {ADDR_W{1'b0}};
      im_wr_en_q   <= 1'b0;
      im_wr_addr_q <= {ADDR_W{1'b0}};
      im_wr_data_q <= {DATA_W{1'b0}};
      dm_wr_en_q   <= 1'b0;
      dm_wr_addr_q <= {ADDR_W{1'b0}};
      dm_wr_data_q <= {DATA_W{1'b0}};
      run_cycles_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ni_q         <= ni_d;
      nd_q         <= nd_d;
      im_wr_en_q   <= im_wr_en_d;
      im_wr_addr_q <= im_wr_addr_d;
      im_wr_data_q <= im_wr_data_d;
      dm_wr_en_q   <= dm_wr_en_d;
      dm_wr_addr_q <= dm_wr_addr_d;
      dm_wr_data_q <= dm_wr_data_d;
      run_cycles_q <= run_cycles_d;
    end
  end

endmodule

// File: tb/tb_nr_boot_sequencer.sv
// Directed testbench for nr_boot_sequencer.
// Inputs change #1 after a rising edge; outputs are sampled at the same point.
module tb_nr_boot_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_wr_en;
  logic [7:0]  im_wr_addr;
  logic [7:0]  im_wr_data;
  logic        dm_wr_en;
  logic [7:0]  dm_wr_addr;
  logic [7:0]  dm_wr_data;
  logic        cpu_reset;
  logic        cpu_halted;
  logic        busy;
  logic        done;
  logic [15:0] run_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // Write-port view: address/data only matter while the strobe is high.
  logic [33:0] wr_obs;
  assign wr_obs = {im_wr_en, im_wr_en ? im_wr_addr : 8'h00, im_wr_en ? im_wr_data : 8'h00,
                   dm_wr_en, dm_wr_en ? dm_wr_addr : 8'h00, dm_wr_en ? dm_wr_data : 8'h00};

  // Status view: {in_ready, cpu_reset, busy, done}
  logic [3:0] st_obs;
  assign st_obs = {in_ready, cpu_reset, busy, done};

  nr_boot_sequencer #(.ADDR_W(8), .DATA_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .im_wr_en   (im_wr_en),
    .im_wr_addr (im_wr_addr),
    .im_wr_data (im_wr_data),
    .dm_wr_en   (dm_wr_en),
    .dm_wr_addr (dm_wr_addr),
    .dm_wr_data (dm_wr_data),
    .cpu_reset  (cpu_reset),
    .cpu_halted (cpu_halted),
    .busy       (busy),
    .done       (done),
    .run_cycles (run_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] exp_w(input logic ie, input logic [7:0] ia, input logic [7:0] id,
                                        input logic de, input logic [7:0] da, input logic [7:0] dd);
    return {ie, ia, id, de, da, dd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; in_data = 8'h00; in_valid = 1'b0; cpu_halted = 1'b0;
    step(); step();
    n_checks++;
    if ({st_obs, wr_obs, run_cycles} !== {4'b0100, 34'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got st=%b wr=%h rc=%0d, want st=0100 wr=0 rc=0", st_obs, wr_obs, run_cycles);
    end
    reset = 1'b1;
    step();
    // cpu_halted while idle must not move the sequencer.
    cpu_halted = 1'b1;
    step();
    cpu_halted = 1'b0;
    n_checks++;
    if (st_obs !== 4'b0100) begin
      n_fail++;
      $display("FAIL idle_halted_ignored: got st=%b want 0100", st_obs);
    end
  endtask

  task automatic test_full_load();
    logic [7:0]  bytes [7];
    logic [33:0] exp   [7];
    bytes = '{8'h03, 8'h02, 8'hC7, 8'h11, 8'hC8, 8'hAA, 8'hBB};
    exp   = '{34'd0, 34'd0,
              exp_w(1'b1, 8'd0, 8'hC7, 1'b0, 8'd0, 8'd0),
              exp_w(1'b1, 8'd1, 8'h11, 1'b0, 8'd0, 8'd0),
              exp_w(1'b1, 8'd2, 8'hC8, 1'b0, 8'd0, 8'd0),
              exp_w(1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 8'hAA),
              exp_w(1'b0, 8'd0, 8'd0, 1'b1, 8'd1, 8'hBB)};
    pulse_start();
    n_checks++;
    if (st_obs !== 4'b1110) begin
      n_fail++;
      $display("FAIL full_after_start: got st=%b want 1110", st_obs);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = bytes[i];
      step();
      n_checks++;
      if (wr_obs !== exp[i]) begin
        n_fail++;
        $display("FAIL full_write_%0d: got %h want %h", i, wr_obs, exp[i]);
      end
    end
    in_valid = 1'b0;
    // RELEASE cycle: core still held, no more bytes taken.
    n_checks++;
    if (st_obs !== 4'b0110) begin
      n_fail++;
      $display("FAIL full_release: got st=%b want 0110", st_obs);
    end
    step();
    n_checks++;
    if ({st_obs, wr_obs, run_cycles} !== {4'b0010, 34'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL full_run_entry: got st=%b wr=%h rc=%0d want st=0010 wr=0 rc=0", st_obs, wr_obs, run_cycles);
    end
    // Ten run cycles; a start pulse during RUN is ignored.
    for (int i = 0; i < 10; i++) begin
      start = (i == 2);
      step();
    end
    start = 1'b0;
    n_checks++;
    if ({st_obs, run_cycles} !== {4'b0010, 16'd10}) begin
      n_fail++;
      $display("FAIL run_count: got st=%b rc=%0d want st=0010 rc=10", st_obs, run_cycles);
    end
    cpu_halted = 1'b1;
    step();
    cpu_halted = 1'b0;
    n_checks++;
    if ({st_obs, run_cycles} !== {4'b0101, 16'd10}) begin
      n_fail++;
      $display("FAIL halted: got st=%b rc=%0d want st=0101 rc=10", st_obs, run_cycles);
    end
    step();
    n_checks++;
    if (run_cycles !== 16'd10) begin
      n_fail++;
      $display("FAIL halted_hold: got rc=%0d want 10", run_cycles);
    end
    pulse_start();
    n_checks++;
    if ({st_obs, run_cycles} !== {4'b1110, 16'd0}) begin
      n_fail++;
      $display("FAIL restart: got st=%b rc=%0d want st=1110 rc=0", st_obs, run_cycles);
    end
  endtask

  // Entered already in HDR_I from the restart above.
  task automatic test_dm_only();
    logic [7:0]  bytes [4];
    logic [33:0] exp   [4];
    bytes = '{8'h00, 8'h02, 8'h5A, 8'hA5};
    exp   = '{34'd0, 34'd0,
              exp_w(1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 8'h5A),
              exp_w(1'b0, 8'd0, 8'd0, 1'b1, 8'd1, 8'hA5)};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = bytes[i];
      step();
      n_checks++;
      if (wr_obs !== exp[i]) begin
        n_fail++;
        $display("FAIL dm_only_write_%0d: got %h want %h", i, wr_obs, exp[i]);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (st_obs !== 4'b0010) begin
      n_fail++;
      $display("FAIL dm_only_run: got st=%b want 0010", st_obs);
    end
    cpu_halted = 1'b1;
    step();
    cpu_halted = 1'b0;
  endtask

  task automatic test_empty();
    pulse_start();
    in_valid = 1'b1;
    in_data  = 8'h00;
    step();
    n_checks++;
    if (wr_obs !== 34'd0) begin
      n_fail++;
      $display("FAIL empty_hdr_i: got %h want 0", wr_obs);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({st_obs, wr_obs} !== {4'b0110, 34'd0}) begin
      n_fail++;
      $display("FAIL empty_release: got st=%b wr=%h want st=0110 wr=0", st_obs, wr_obs);
    end
    step();
    n_checks++;
    if ({st_obs, wr_obs} !== {4'b0010, 34'd0}) begin
      n_fail++;
      $display("FAIL empty_run: got st=%b wr=%h want st=0010 wr=0", st_obs, wr_obs);
    end
    cpu_halted = 1'b1;
    step();
    cpu_halted = 1'b0;
  endtask

  task automatic test_stalls();
    logic [7:0]  bytes [4];
    logic [33:0] exp   [4];
    bytes = '{8'h02, 8'h00, 8'h11, 8'h22};
    exp   = '{34'd0, 34'd0,
              exp_w(1'b1, 8'd0, 8'h11, 1'b0, 8'd0, 8'd0),
              exp_w(1'b1, 8'd1, 8'h22, 1'b0, 8'd0, 8'd0)};
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = bytes[i];
      step();
      n_checks++;
      if (wr_obs !== exp[i]) begin
        n_fail++;
        $display("FAIL stall_write_%0d: got %h want %h", i, wr_obs, exp[i]);
      end
      in_valid = 1'b0;
      in_data  = 8'hEE;
      if (i < 3) begin
        for (int s = 0; s < 3; s++) begin
          step();
          n_checks++;
          if ({st_obs, wr_obs} !== {4'b1110, 34'd0}) begin
            n_fail++;
            $display("FAIL stall_hold_%0d_%0d: got st=%b wr=%h want st=1110 wr=0", i, s, st_obs, wr_obs);
          end
        end
      end
    end
    n_checks++;
    if (st_obs !== 4'b0110) begin
      n_fail++;
      $display("FAIL stall_release: got st=%b want 0110", st_obs);
    end
    step();
    cpu_halted = 1'b1;
    step();
    cpu_halted = 1'b0;
  endtask

  task automatic test_reset_midload();
    logic [7:0]  bytes [5];
    logic [33:0] exp   [5];
    pulse_start();
    in_valid = 1'b1;
    in_data = 8'h03; step();
    in_data = 8'h00; step();
    in_data = 8'hC7; step();
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({st_obs, wr_obs} !== {4'b0100, 34'd0}) begin
      n_fail++;
      $display("FAIL midload_reset: got st=%b wr=%h want st=0100 wr=0", st_obs, wr_obs);
    end
    step();
    reset = 1'b1;
    step();
    bytes = '{8'h03, 8'h00, 8'hA1, 8'hB2, 8'hC3};
    exp   = '{34'd0, 34'd0,
              exp_w(1'b1, 8'd0, 8'hA1, 1'b0, 8'd0, 8'd0),
              exp_w(1'b1, 8'd1, 8'hB2, 1'b0, 8'd0, 8'd0),
              exp_w(1'b1, 8'd2, 8'hC3, 1'b0, 8'd0, 8'd0)};
    pulse_start();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = bytes[i];
      step();
      n_checks++;
      if (wr_obs !== exp[i]) begin
        n_fail++;
        $display("FAIL reload_write_%0d: got %h want %h", i, wr_obs, exp[i]);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if ({st_obs, wr_obs} !== {4'b0010, 34'd0}) begin
      n_fail++;
      $display("FAIL reload_run: got st=%b wr=%h want st=0010 wr=0", st_obs, wr_obs);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_dm_only();
    test_empty();
    test_stalls();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nr_boot_sequencer.md
Name: nr_boot_sequencer

Overview:
- Loads a program image into the nanoRisk processor, then starts it and supervises it.
- Accepts a byte stream over a valid/ready handshake and writes instruction memory and data memory through their write ports.
- Holds the core in reset while loading, releases it, counts run cycles until the core halts, and reports completion.
- Sits between the host/testbench and the processor top; replaces hard-coded memory preload.

Parameters:
- ADDR_W, 8, address width of both memories (depth 2^ADDR_W).
- DATA_W, 8, memory word and stream byte width.
- CNT_W, 16, width of the run-cycle counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE or HALTED.
- in_data  in  DATA_W  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts a byte this cycle.
- im_wr_en  out  1  instruction memory write strobe.
- im_wr_addr  out  ADDR_W  instruction memory write address.
- im_wr_data  out  DATA_W  instruction memory write data.
- dm_wr_en  out  1  data memory write strobe.
- dm_wr_addr  out  ADDR_W  data memory write address.
- dm_wr_data  out  DATA_W  data memory write data.
- cpu_reset  out  1  active-high reset to the processor core.
- cpu_halted  in  1  core has executed halt; level signal.
- busy  out  1  high in every state except IDLE and HALTED.
- done  out  1  high in HALTED.
- run_cycles  out  CNT_W  cycles spent in RUN; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - in_ready=0, im_wr_en=0, dm_wr_en=0.
  - All addr/data outputs 0.
  - cpu_reset=1, busy=0, done=0, run_cycles=0.
- Transfer: a byte is taken on a rising edge with in_valid=1 and in_ready=1. in_ready is combinational from state only: 1 in HDR_I, HDR_D, LOAD_I, LOAD_D; 0 otherwise.
- States:
  - IDLE: cpu_reset=1. start → HDR_I; run_cycles clears to 0.
  - HDR_I: the accepted byte is ni, the instruction byte count (0..255) → HDR_D.
  - HDR_D: the accepted byte is nd, the data byte count.
    - ni>0 → LOAD_I.
    - ni=0, nd>0 → LOAD_D.
    - both 0 → RELEASE.
  - LOAD_I: the k-th accepted byte (k=0..ni-1) is written to IM address k.
    - On byte ni-1: nd>0 → LOAD_D, else → RELEASE.
  - LOAD_D: the k-th accepted byte is written to DM address k.
    - On byte nd-1 → RELEASE.
  - RELEASE: one cycle. cpu_reset stays 1 → RUN.
  - RUN: cpu_reset=0. run_cycles increments each cycle (saturating). cpu_halted=1 sampled → HALTED; no increment on that edge.
  - HALTED: cpu_reset=1, done=1, run_cycles holds. start → HDR_I; run_cycles clears.
- Write timing:
  - Write strobes are registered: addr/data/wr_en assert on the edge that accepts the byte and last exactly one cycle.
  - A write for the final byte is issued in the first cycle of the next state.
  - Writes are never issued for header bytes.
  - Back-to-back valid bytes give back-to-back writes with no bubbles.
- Stalls: in_valid low holds the state and counters; no write is issued.
- start in any other state (HDR_*, LOAD_*, RELEASE, RUN) is ignored.
- Mid-load or mid-run reset: abandons immediately to IDLE with cpu_reset=1. Partially written memory is left as-is.
- cpu_halted outside RUN is ignored.
- The internal byte counter is ADDR_W bits and never wraps, because ni/nd ≤ 2^ADDR_W−1.

Test Plan:
- Reset then start; stream 03,02,C7,11,C8,AA,BB with in_valid held high → IM[0..2]=C7,11,C8 and DM[0..1]=AA,BB on consecutive cycles. cpu_reset falls one cycle after the DM[1] write issues.
- Header 00,02,5A,A5 → no IM writes; DM[0]=5A, DM[1]=A5; reaches RUN.
- Header 00,00 → straight to RELEASE then RUN; no write strobes at all.
- Drive in_valid low for 3 cycles between every byte of a 02,00,11,22 load → IM[0]=11, IM[1]=22 only; state and address are frozen during stalls.
- In RUN, assert cpu_halted after 10 cycles → done=1, cpu_reset=1, run_cycles=10. Then start → busy=1, run_cycles=0.
- Drop reset mid-LOAD_I after 1 of 3 bytes → in IDLE immediately, cpu_reset=1, in_ready=0. A subsequent start and full stream loads correctly from IM address 0.
